uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
- Buffered 8N1 UART transmitter.
- Producers (receive-done strobes, test pattern generators, command responders) push bytes through a single-cycle write strobe. The block queues them in an internal FIFO and serialises them on the tx line back to back.
- It is the transmit-side counterpart of the byte receiver. It lets an echo path absorb bursts of received bytes without dropping any while a frame is still on the line.

Parameters:
- sys_clk_freq, 50_000_000: sclk frequency in Hz.
- baudrate, 115200: line rate in bit/s. BIT_CYC = sys_clk_freq / baudrate, integer-truncated (434 at defaults).
- FIFO_DEPTH, 16: byte queue depth. Must be a power of 2, minimum 2.

Ports:
- sclk  input  1  system clock, all logic on rising edge
- nrst  input  1  asynchronous active-low reset
- wr_en  input  1  one-cycle strobe; pushes wr_byte
- wr_byte  input  8  byte to transmit
- full  output  1  FIFO holds FIFO_DEPTH bytes
- overflow  output  1  one-cycle pulse when wr_en arrives while full
- busy  output  1  frame on line, or FIFO not empty
- tx_done  output  1  one-cycle pulse on the last clock of each stop bit
- tx  output  1  serial line, idle high

Behaviour:
- Interface: one clock (sclk). Reset nrst is asynchronous, active-low, and fully decided.
- Reset values: tx=1, full=0, overflow=0, busy=0, tx_done=0. FIFO pointers and count are 0. FSM is in IDLE, bit and baud counters are 0.
- Reset mid-frame: tx returns to 1 immediately (asynchronously). The queued contents are discarded.
- FIFO write acceptance:
  - A write is accepted when wr_en=1 and full=0 in the same cycle.
  - When wr_en=1 and full=1, the write is dropped and overflow pulses on the next cycle.
  - A pop in the same cycle does not free a slot for that cycle's write. Full is evaluated before the pop.
- FIFO count and full:
  - The count is log2(FIFO_DEPTH)+1 bits wide.
  - Pointers wrap modulo FIFO_DEPTH.
  - full is registered and equals (count == FIFO_DEPTH).
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If the FIFO is non-empty: pop into shift register sh[7:0], clear the baud counter, go to START.
  - Latency: a write captured on edge N into an empty FIFO while IDLE gives tx=0 after edge N+1.
- START:
  - tx=0 for BIT_CYC clocks, then go to DATA with bit_idx=0.
- DATA:
  - tx=sh[bit_idx], LSB first, each bit held BIT_CYC clocks.
  - After bit_idx=7, go to STOP.
- STOP:
  - tx=1 for BIT_CYC clocks.
  - tx_done=1 on the final clock of the stop bit.
  - On that same clock: if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Frame timing: exactly 10*BIT_CYC clocks per frame. Back-to-back frames have no extra cycles between them.
- tx is driven from a register (glitch-free).
- busy = (state != IDLE) or (count != 0).

Decomposition:
- Shared package/include holds:
  - the state encodings (IDLE=0, START=1, DATA=2, STOP=3);
  - the BIT_CYC computation, so the receiver uses the identical divisor.
- One natural sub-module: sync_fifo_byte. Parameterised depth, width 8, with wr_en, rd_en, din, dout, count, full, empty.
- The FSM, baud counter and shifter stay in the top.

Test Plan:
- Basic frame: after reset, write 0x55 once. tx falls one cycle after the write edge, then shows 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each bit 434 clocks. tx_done pulses once at clock 4340 of the frame. busy drops on the following cycle.
- Back-to-back: write 0x00, 0xFF, 0xA5 on consecutive cycles. Three frames are contiguous (start bit follows stop with no gap), tx_done pulses exactly 3 times spaced 4340 clocks apart, and the decoded bytes match.
- Full and overflow:
  - Write 17 bytes (0x00..0x10) on 17 consecutive cycles while IDLE. The first is popped immediately, so all 17 are accepted and full asserts at the 17th.
  - An 18th write is dropped with a single overflow pulse.
  - 17 frames are emitted in order.
- Simultaneous write and pop at full:
  - With full=1 on the last clock of a STOP, strobe wr_en. The write is dropped (overflow pulses) while the pop proceeds.
  - full deasserts on the next cycle.
- Reset mid-frame: assert nrst=0 during DATA bit 3. tx goes to 1 asynchronously. After release, no residual frame is sent; busy=0 and full=0. A new write of 0x3C transmits correctly.
- Baud parameter sweep: instantiate with baudrate=9600. Bit period is 5208 clocks and frame length is 52080 clocks.

Source files
------------

// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter and its receive-side
// counterpart.
//   tx_state_t     : transmitter FSM encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   calc_bit_cyc() : clocks per bit. Both directions call this one function
//                    so they always agree on the divisor.
package uart_tx_buffered_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Integer-truncated divisor (434 for 50 MHz / 115200).
    function automatic int calc_bit_cyc(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// sync_fifo_byte: single-clock byte FIFO with first-word fall-through output.
//   sclk   : clock, rising edge
//   nrst   : asynchronous active-low reset (pointers and count only)
//   wr_en  : push din; ignored while full
//   rd_en  : pop; dout already shows the head entry, so it is consumed the
//            same cycle rd_en is high; ignored while empty
//   din    : byte to push
//   dout   : head entry (undefined while empty)
//   count  : number of stored bytes, 0..DEPTH
//   full   : registered, count == DEPTH
//   empty  : count == 0
// Handshake: a push happens on an edge where wr_en=1 and full=0. A pop happens
// on an edge where rd_en=1 and empty=0. full is the registered value, so a pop
// in the same cycle never frees room for that cycle's push.
module sync_fifo_byte
    import uart_tx_buffered_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     sclk,
    input  logic                     nrst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic          wr_acc;
    logic          rd_acc;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;
    assign empty  = (count == '0);
    assign dout   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + 1'b1;
        end else if (!wr_acc && rd_acc) begin
            count_next = count - 1'b1;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
        end
    end

    // Storage has no reset; stale data is never visible because empty gates pops.
    always_ff @(posedge sclk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter behind a byte FIFO.
//   sclk     : system clock, rising edge
//   nrst     : asynchronous active-low reset; forces tx high and empties the queue
//   wr_en    : one-cycle strobe that pushes wr_byte (dropped while full)
//   wr_byte  : byte to send
//   full     : queue holds FIFO_DEPTH bytes
//   overflow : one-cycle pulse, the cycle after a wr_en that arrived while full
//   busy     : a frame is on the line or bytes are still queued
//   tx_done  : high on the last clock of each stop bit
//   tx       : serial line, idle high, driven from a flop
// Handshake: there is no ready. A producer may strobe wr_en any cycle. The
// byte is accepted iff full=0 in that cycle, otherwise overflow reports the drop.
// Frames are exactly 10*BIT_CYC clocks. A queued byte is popped on the final
// stop clock, so consecutive frames have no gap between them.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int sys_clk_freq = 50_000_000,
    parameter int baudrate     = 115200,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       sclk,
    input  logic       nrst,
    input  logic       wr_en,
    input  logic [7:0] wr_byte,
    output logic       full,
    output logic       overflow,
    output logic       busy,
    output logic       tx_done,
    output logic       tx
);

    localparam int BIT_CYC = calc_bit_cyc(sys_clk_freq, baudrate);
    localparam int CNT_W   = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
    localparam int FCW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);
    // tx_done is a flop, so it is set one clock early to line up with the
    // final stop clock.
    localparam logic [CNT_W-1:0] DONE_AT  = CNT_W'(BIT_CYC - 2);

    tx_state_t        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       sh;
    logic             bit_end;
    logic             pop;
    logic [7:0]       fifo_dout;
    logic [FCW-1:0]   fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    sync_fifo_byte #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sclk  (sclk),
        .nrst  (nrst),
        .wr_en (wr_en),
        .rd_en (pop),
        .din   (wr_byte),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bit_end = (baud_cnt == BIT_LAST);
    // Pop from IDLE at once, or on the last stop clock to chain the next frame.
    assign pop     = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
    assign full    = fifo_full;
    assign busy    = (state != IDLE) || (fifo_count != '0);

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            sh       <= '0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && fifo_full;
            tx_done  <= (state == STOP) && (baud_cnt == DONE_AT);
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (!fifo_empty) begin
                        sh    <= fifo_dout;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= sh[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= sh[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (!fifo_empty) begin
                            sh    <= fifo_dout;
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered. Three instances share one clock:
//   0: default rates (BIT_CYC 434)  - basic frame, back-to-back frames
//   1: fast rate (BIT_CYC 16)       - full/overflow, pop at full, reset mid-frame
//   2: 9600 baud (BIT_CYC 5208)     - slow frame, runs alongside the others
// Stimulus pushes expected bytes into per-instance queues. One monitor per
// instance decodes every frame, checks the exact per-clock waveform and the
// tx_done position, and compares the decoded byte with the queue head.
module tb_uart_tx_buffered;

    localparam int BC0 = 434;
    localparam int BC1 = 16;
    localparam int BC2 = 5208;

    logic       sclk;
    logic       nrst_v     [3];
    logic       wr_en_v    [3];
    logic [7:0] wr_byte_v  [3];
    logic       full_v     [3];
    logic       overflow_v [3];
    logic       busy_v     [3];
    logic       tx_done_v  [3];
    logic       tx_v       [3];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int frames_done [3];
    int b2b [3];

    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];
    logic [7:0] exp_q2 [$];

    // ---------------- clock ----------------
    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    always @(posedge sclk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    uart_tx_buffered u_dut0 (
        .sclk(sclk), .nrst(nrst_v[0]), .wr_en(wr_en_v[0]), .wr_byte(wr_byte_v[0]),
        .full(full_v[0]), .overflow(overflow_v[0]), .busy(busy_v[0]),
        .tx_done(tx_done_v[0]), .tx(tx_v[0])
    );

    uart_tx_buffered #(.sys_clk_freq(50_000_000), .baudrate(3_125_000), .FIFO_DEPTH(16)) u_dut1 (
        .sclk(sclk), .nrst(nrst_v[1]), .wr_en(wr_en_v[1]), .wr_byte(wr_byte_v[1]),
        .full(full_v[1]), .overflow(overflow_v[1]), .busy(busy_v[1]),
        .tx_done(tx_done_v[1]), .tx(tx_v[1])
    );

    uart_tx_buffered #(.sys_clk_freq(50_000_000), .baudrate(9600), .FIFO_DEPTH(16)) u_dut2 (
        .sclk(sclk), .nrst(nrst_v[2]), .wr_en(wr_en_v[2]), .wr_byte(wr_byte_v[2]),
        .full(full_v[2]), .overflow(overflow_v[2]), .busy(busy_v[2]),
        .tx_done(tx_done_v[2]), .tx(tx_v[2])
    );

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int idx, input logic [7:0] b);
        case (idx)
            0:       exp_q0.push_back(b);
            1:       exp_q1.push_back(b);
            default: exp_q2.push_back(b);
        endcase
    endtask

    task automatic pop_exp(input int idx, output bit have, output logic [7:0] b);
        have = 1'b0;
        b    = 8'h00;
        case (idx)
            0:       if (exp_q0.size() > 0) begin have = 1'b1; b = exp_q0.pop_front(); end
            1:       if (exp_q1.size() > 0) begin have = 1'b1; b = exp_q1.pop_front(); end
            default: if (exp_q2.size() > 0) begin have = 1'b1; b = exp_q2.pop_front(); end
        endcase
    endtask

    // Drive one write strobe for one cycle; returns at the negedge after the write edge.
    task automatic wr(input int idx, input logic [7:0] b, input bit accept);
        wr_en_v[idx]   = 1'b1;
        wr_byte_v[idx] = b;
        if (accept) push_exp(idx, b);
        @(negedge sclk);
        wr_en_v[idx] = 1'b0;
    endtask

    task automatic wait_frames(input int idx, input int target, input int budget);
        int k;
        k = 0;
        while (frames_done[idx] < target && k < budget) begin
            @(posedge sclk);
            k++;
        end
        checks++;
        if (frames_done[idx] < target) begin
            errors++;
            $display("FAIL frame_timeout[%0d]: got %0d frames, required %0d", idx, frames_done[idx], target);
        end
        @(negedge sclk);
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic monitor(input int idx, input int bc);
        logic [9:0] bits;
        logic [7:0] e;
        logic [7:0] got;
        bit         have;
        bit         aborted;
        int         bad;
        int         end_cyc;
        end_cyc = -100;
        forever begin
            @(negedge sclk);
            if (nrst_v[idx] === 1'b1 && tx_v[idx] === 1'b0) begin
                if (cyc == end_cyc + 1) b2b[idx]++;
                pop_exp(idx, have, e);
                checks++;
                if (!have) begin
                    errors++;
                    $display("FAIL unexpected_frame[%0d]: got a start bit, required idle line", idx);
                end
                bits    = {1'b1, e, 1'b0};
                got     = 8'h00;
                bad     = 0;
                aborted = 1'b0;
                for (int c = 1; c <= 10 * bc; c++) begin
                    if (c > 1) @(negedge sclk);
                    if (nrst_v[idx] !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (tx_v[idx] !== bits[(c - 1) / bc]) bad++;
                    if (tx_done_v[idx] !== (c == 10 * bc)) bad++;
                    if ((c - 1) / bc >= 1 && (c - 1) / bc <= 8 && (c - 1) % bc == bc / 2)
                        got[(c - 1) / bc - 1] = tx_v[idx];
                end
                if (!aborted) begin
                    end_cyc = cyc;
                    frames_done[idx]++;
                    if (have) begin
                        chk($sformatf("frame_byte[%0d]", idx), {24'h0, got}, {24'h0, e});
                        chk($sformatf("frame_wave_errs[%0d]", idx), bad, 0);
                    end
                end
            end
        end
    endtask

    initial monitor(0, BC0);
    initial monitor(1, BC1);
    initial monitor(2, BC2);

    // ---------------- stimulus ----------------
    initial begin
        int f;
        int base;
        for (int i = 0; i < 3; i++) begin
            nrst_v[i]      = 1'b0;
            wr_en_v[i]     = 1'b0;
            wr_byte_v[i]   = 8'h00;
            frames_done[i] = 0;
            b2b[i]         = 0;
        end
        repeat (4) @(negedge sclk);
        for (int i = 0; i < 3; i++) nrst_v[i] = 1'b1;
        @(negedge sclk);

        chk("reset_tx", tx_v[0], 1);
        chk("reset_full", full_v[0], 0);
        chk("reset_overflow", overflow_v[0], 0);
        chk("reset_busy", busy_v[0], 0);
        chk("reset_tx_done", tx_done_v[0], 0);

        fork
            begin : default_rate
                // Basic frame 0x55.
                wr(0, 8'h55, 1);
                chk("tx_high_after_write_edge", tx_v[0], 1);
                chk("busy_after_write", busy_v[0], 1);
                @(negedge sclk);
                chk("tx_start_latency", tx_v[0], 0);
                wait_frames(0, 1, 10 * BC0 + 20);
                chk("busy_drop_after_frame", busy_v[0], 0);
                chk("tx_idle_after_frame", tx_v[0], 1);

                // Back-to-back 0x00, 0xFF, 0xA5.
                base = b2b[0];
                wr(0, 8'h00, 1);
                wr(0, 8'hFF, 1);
                wr(0, 8'hA5, 1);
                wait_frames(0, 4, 30 * BC0 + 40);
                chk("b2b_contiguous", b2b[0] - base, 2);
                chk("busy_after_b2b", busy_v[0], 0);
            end
            begin : fast_rate
                // 17 writes while IDLE; 18th dropped.
                base = b2b[1];
                f    = frames_done[1];
                for (int i = 0; i < 17; i++) begin
                    wr(1, 8'(i), 1);
                    if (i == 15) chk("full_before_17th", full_v[1], 0);
                end
                chk("full_at_17th", full_v[1], 1);
                wr(1, 8'h11, 0);
                chk("overflow_pulse", overflow_v[1], 1);
                @(negedge sclk);
                chk("overflow_single", overflow_v[1], 0);
                wait_frames(1, f + 17, 170 * BC1 + 40);
                chk("burst_contiguous", b2b[1] - base, 16);
                chk("busy_after_burst", busy_v[1], 0);

                // Write while full on the last stop clock: dropped, pop proceeds.
                f = frames_done[1];
                for (int i = 0; i < 17; i++) wr(1, 8'(32 + i), 1);
                for (int k = 0; k < 300 && tx_done_v[1] !== 1'b1; k++) @(negedge sclk);
                chk("tx_done_seen", tx_done_v[1], 1);
                chk("full_at_stop_end", full_v[1], 1);
                wr(1, 8'hEE, 0);
                chk("overflow_at_pop", overflow_v[1], 1);
                chk("full_released", full_v[1], 0);
                wait_frames(1, f + 17, 170 * BC1 + 40);
                chk("busy_after_pop_full", busy_v[1], 0);

                // Reset during DATA bit 3 of 0x96, with two more bytes queued.
                f = frames_done[1];
                wr(1, 8'h96, 1);
                wr(1, 8'h11, 1);
                wr(1, 8'h22, 1);
                repeat (70) @(negedge sclk);
                chk("tx_data_bit3", tx_v[1], 0);
                #2 nrst_v[1] = 1'b0;
                #1;
                chk("tx_async_reset", tx_v[1], 1);
                chk("busy_in_reset", busy_v[1], 0);
                exp_q1.delete();
                repeat (3) @(negedge sclk);
                #2 nrst_v[1] = 1'b1;
                repeat (200) @(negedge sclk);
                chk("no_residual_frame", frames_done[1] - f, 0);
                chk("busy_after_reset", busy_v[1], 0);
                chk("full_after_reset", full_v[1], 0);
                chk("tx_after_reset", tx_v[1], 1);
                wr(1, 8'h3C, 1);
                wait_frames(1, f + 1, 10 * BC1 + 20);
                chk("busy_after_3c", busy_v[1], 0);
            end
            begin : slow_rate
                wr(2, 8'hA3, 1);
                wait_frames(2, 1, 10 * BC2 + 20);
                chk("busy_after_slow", busy_v[2], 0);
            end
        join

        repeat (5) @(negedge sclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
